// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU bus-access sequencer.
// Covers request size encodings, FSM states and the beat-count arithmetic.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int BEAT_W = 3;

  // A request narrower than the bus still needs one beat.
  function automatic logic [BEAT_W-1:0] beat_count(input size_e size, input int bus_w);
    int bits;
    int n;
    bits = 8 << size;
    n    = bits / bus_w;
    if (n < 1) n = 1;
    return n[BEAT_W-1:0];
  endfunction

  function automatic logic size_ok(input size_e size, input int data_w);
    return (size != SZ_RSVD) && ((8 << size) <= data_w);
  endfunction

endpackage

// File: rtl/cpu_bus_seq_if.sv
// CPU request/response and external bus signals of the sequencer.
// slave = sequencer view, master = CPU core / bus environment view.
interface cpu_bus_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BUS_W  = 8
);
  logic              i_req_valid;
  logic              o_req_ready;
  logic              i_req_we;
  logic [1:0]        i_req_size;
  logic [ADDR_W-1:0] i_req_addr;
  logic [DATA_W-1:0] i_req_wdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [DATA_W-1:0] o_rsp_rdata;
  logic              o_rsp_err;
  logic              o_bus_clk;
  logic              o_bus_we;
  logic [ADDR_W-1:0] o_bus_addr;
  logic [BUS_W-1:0]  o_bus_data;
  logic [BUS_W-1:0]  i_bus_data;
  logic              i_bus_data_ready;
  logic              o_busy;

  modport slave (
    input  i_req_valid, i_req_we, i_req_size, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_bus_data, i_bus_data_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_bus_clk, o_bus_we, o_bus_addr, o_bus_data, o_busy
  );

  modport master (
    output i_req_valid, i_req_we, i_req_size, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_bus_data, i_bus_data_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_bus_clk, o_bus_we, o_bus_addr, o_bus_data, o_busy
  );
endinterface

// File: rtl/cpu_bus_timer.sv
// Per-beat wait counter; expired_o flags the cycle in which the limit is reached.
// LIMIT = 0 disables expiry entirely.
module cpu_bus_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires during the LIMIT-th consecutive cycle without ready.
  generate
    if (LIMIT > 0) begin : g_limit
      assign expired_o = en_i && (cnt_q == CNT_W'(LIMIT - 1));
    end else begin : g_nolimit
      assign expired_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/cpu_bus_seq.sv
// Bus-access sequencer: splits a 1/2/4-byte load/store into little-endian
// BUS_W-wide beats, each handshaked on i_bus_data_ready with optional timeout.
module cpu_bus_seq
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BUS_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic          i_cpu_clk,
  input logic          i_rst_n,
  cpu_bus_seq_if.slave bus_if
);
  localparam int BPB = BUS_W / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  size_e             size_q, size_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic [BEAT_W-1:0] nbeats;
  size_e             req_size;
  logic              tmr_clr, tmr_en, tmr_expired;

  function automatic logic [DATA_W-1:0] byte_mask(input size_e s);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (i < (1 << s)) m[i*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  assign req_size = size_e'(bus_if.i_req_size);
  assign nbeats   = beat_count(size_q, BUS_W);

  assign tmr_clr = (state_q != ST_WAIT);
  assign tmr_en  = (state_q == ST_WAIT) && !bus_if.i_bus_data_ready;

  cpu_bus_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk_i     (i_cpu_clk),
    .rst_ni    (i_rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.i_req_valid) begin
          addr_d  = bus_if.i_req_addr;
          size_d  = req_size;
          we_d    = bus_if.i_req_we;
          rdata_d = '0;
          beat_d  = '0;
          // Masking store data here keeps unused upper bus lanes at zero.
          if (size_ok(req_size, DATA_W)) begin
            wdata_d = bus_if.i_req_we ? (bus_if.i_req_wdata & byte_mask(req_size)) : '0;
            err_d   = 1'b0;
            state_d = ST_SETUP;
          end else begin
            wdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_if.i_bus_data_ready) begin
          if (!we_q) begin
            rdata_d[int'(beat_q)*BUS_W +: BUS_W] = bus_if.i_bus_data;
            rdata_d = rdata_d & byte_mask(size_q);
          end
          if (beat_q == nbeats - 1'b1) begin
            state_d = ST_RESP;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = ST_SETUP;
          end
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_if.i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_cpu_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign bus_if.o_req_ready = (state_q == ST_IDLE);
  assign bus_if.o_busy      = (state_q != ST_IDLE);
  assign bus_if.o_rsp_valid = (state_q == ST_RESP);
  assign bus_if.o_rsp_rdata = rdata_q;
  assign bus_if.o_rsp_err   = err_q;
  assign bus_if.o_bus_clk   = (state_q == ST_WAIT);
  assign bus_if.o_bus_we    = we_q && ((state_q == ST_SETUP) || (state_q == ST_WAIT));
  assign bus_if.o_bus_addr  = addr_q + ADDR_W'(int'(beat_q) * BPB);
  assign bus_if.o_bus_data  = wdata_q[int'(beat_q)*BUS_W +: BUS_W];

endmodule

// File: tb/tb_cpu_bus_seq.sv
// Directed bench for cpu_bus_seq: dut_a uses an 8-bit bus with a 4-cycle timeout,
// dut_b a 16-bit bus; sel routes the shared stimulus to one of them.
module tb_cpu_bus_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel;
  logic        req_valid, req_we, rsp_ready, bus_rdy;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, bus_rdata;

  int n_chk = 0, n_pass = 0;
  int nlog = 0, wait_cnt = 0, rdy_left = 0, k;
  logic [31:0] rd_vals [4];
  logic [31:0] log_addr [8];
  logic [31:0] log_data [8];
  logic        log_we [8];
  logic        found;

  cpu_bus_seq_if #(.ADDR_W(32), .DATA_W(32), .BUS_W(8))  ifa ();
  cpu_bus_seq_if #(.ADDR_W(32), .DATA_W(32), .BUS_W(16)) ifb ();

  cpu_bus_seq #(.ADDR_W(32), .DATA_W(32), .BUS_W(8), .TIMEOUT_CYC(4)) dut_a (
    .i_cpu_clk(clk), .i_rst_n(rst_n), .bus_if(ifa));
  cpu_bus_seq #(.ADDR_W(32), .DATA_W(32), .BUS_W(16), .TIMEOUT_CYC(255)) dut_b (
    .i_cpu_clk(clk), .i_rst_n(rst_n), .bus_if(ifb));

  assign ifa.i_req_valid      = req_valid & ~sel;
  assign ifb.i_req_valid      = req_valid & sel;
  assign ifa.i_req_we         = req_we;
  assign ifb.i_req_we         = req_we;
  assign ifa.i_req_size       = req_size;
  assign ifb.i_req_size       = req_size;
  assign ifa.i_req_addr       = req_addr;
  assign ifb.i_req_addr       = req_addr;
  assign ifa.i_req_wdata      = req_wdata;
  assign ifb.i_req_wdata      = req_wdata;
  assign ifa.i_rsp_ready      = rsp_ready & ~sel;
  assign ifb.i_rsp_ready      = rsp_ready & sel;
  assign ifa.i_bus_data       = bus_rdata[7:0];
  assign ifb.i_bus_data       = bus_rdata[15:0];
  assign ifa.i_bus_data_ready = bus_rdy & ~sel;
  assign ifb.i_bus_data_ready = bus_rdy & sel;

  wire        m_req_ready = sel ? ifb.o_req_ready : ifa.o_req_ready;
  wire        m_rsp_valid = sel ? ifb.o_rsp_valid : ifa.o_rsp_valid;
  wire        m_rsp_err   = sel ? ifb.o_rsp_err   : ifa.o_rsp_err;
  wire [31:0] m_rdata     = sel ? ifb.o_rsp_rdata : ifa.o_rsp_rdata;
  wire        m_bus_clk   = sel ? ifb.o_bus_clk   : ifa.o_bus_clk;
  wire        m_bus_we    = sel ? ifb.o_bus_we    : ifa.o_bus_we;
  wire [31:0] m_bus_addr  = sel ? ifb.o_bus_addr  : ifa.o_bus_addr;
  wire [31:0] m_bus_data  = sel ? {16'h0, ifb.o_bus_data} : {24'h0, ifa.o_bus_data};
  wire        m_busy      = sel ? ifb.o_busy      : ifa.o_busy;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Bus slave: answers in the first WAIT cycle while rdy_left allows, logs each beat.
  initial begin
    bus_rdy   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (m_bus_clk) wait_cnt++;
      if (m_bus_clk && rdy_left > 0) begin
        bus_rdy = 1'b1;
        bus_rdata = rd_vals[nlog % 4];
        log_addr[nlog % 8] = m_bus_addr;
        log_data[nlog % 8] = m_bus_data;
        log_we[nlog % 8]   = m_bus_we;
        nlog++;
        rdy_left--;
      end else begin
        bus_rdy = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
    @(negedge clk);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    chk("req_ready_before_accept", 32'(m_req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!m_rsp_valid && cyc < 50) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("rsp_valid_seen", 32'(m_rsp_valid), 1);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("idle_after_rsp", 32'(m_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_addr = '0; req_wdata = '0;
    rd_vals[0] = 0; rd_vals[1] = 0; rd_vals[2] = 0; rd_vals[3] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(m_req_ready), 1);
    chk("rst_rsp_valid", 32'(m_rsp_valid), 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_bus_clk", 32'(m_bus_clk), 0);
    chk("rst_bus_addr", m_bus_addr, 0);
    chk("rst_rdata", m_rdata, 0);
    rst_n = 1'b1;

    // 4-byte store over an 8-bit bus, crossing a 0x200 boundary
    rdy_left = 100; nlog = 0;
    do_req(1'b1, 2'b10, 32'h0000_01FE, 32'hAABB_CCDD);
    wait_rsp(k);
    chk("st4_latency", k, 9);
    chk("st4_err", 32'(m_rsp_err), 0);
    chk("st4_rdata", m_rdata, 0);
    chk("st4_beats", nlog, 4);
    chk("st4_a0", log_addr[0], 32'h1FE);
    chk("st4_a1", log_addr[1], 32'h1FF);
    chk("st4_a2", log_addr[2], 32'h200);
    chk("st4_a3", log_addr[3], 32'h201);
    chk("st4_d0", log_data[0], 32'hDD);
    chk("st4_d1", log_data[1], 32'hCC);
    chk("st4_d2", log_data[2], 32'hBB);
    chk("st4_d3", log_data[3], 32'hAA);
    chk("st4_we", 32'(log_we[0] & log_we[1] & log_we[2] & log_we[3]), 1);
    take_rsp();

    // 2-byte load wrapping the top of the address space
    nlog = 0; rd_vals[0] = 32'h34; rd_vals[1] = 32'h12;
    do_req(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
    wait_rsp(k);
    chk("ld2_a0", log_addr[0], 32'hFFFF_FFFF);
    chk("ld2_a1", log_addr[1], 32'h0000_0000);
    chk("ld2_we", 32'(log_we[0] | log_we[1]), 0);
    chk("ld2_rdata", m_rdata, 32'h0000_1234);
    chk("ld2_err", 32'(m_rsp_err), 0);
    take_rsp();

    // timeout: bus never answers
    rdy_left = 0; nlog = 0; wait_cnt = 0;
    do_req(1'b0, 2'b00, 32'h10, 32'h0);
    wait_rsp(k);
    chk("to_wait_cycles", wait_cnt, 4);
    chk("to_latency", k, 6);
    chk("to_err", 32'(m_rsp_err), 1);
    chk("to_rdata", m_rdata, 0);
    take_rsp();

    // reserved size: immediate error, response held under back-pressure
    rdy_left = 100; nlog = 0; wait_cnt = 0;
    do_req(1'b0, 2'b11, 32'h20, 32'h0);
    wait_rsp(k);
    chk("rsvd_latency", k, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rsvd_hold_valid", 32'(m_rsp_valid), 1);
      chk("rsvd_hold_err", 32'(m_rsp_err), 1);
      chk("rsvd_hold_ready", 32'(m_req_ready), 0);
    end
    chk("rsvd_no_bus", wait_cnt, 0);
    chk("rsvd_rdata", m_rdata, 0);
    take_rsp();

    // 16-bit bus instance
    sel = 1'b1; nlog = 0; rd_vals[0] = 32'h5678; rd_vals[1] = 32'h1234;
    do_req(1'b0, 2'b10, 32'h100, 32'h0);
    wait_rsp(k);
    chk("b16_latency", k, 5);
    chk("b16_a0", log_addr[0], 32'h100);
    chk("b16_a1", log_addr[1], 32'h102);
    chk("b16_rdata", m_rdata, 32'h1234_5678);
    take_rsp();
    nlog = 0; rd_vals[0] = 32'hBEEF;
    do_req(1'b0, 2'b00, 32'h40, 32'h0);
    wait_rsp(k);
    chk("b16_byte_rdata", m_rdata, 32'h0000_00EF);
    chk("b16_byte_beats", nlog, 1);
    take_rsp();
    nlog = 0;
    do_req(1'b1, 2'b00, 32'h41, 32'h1234_56A5);
    wait_rsp(k);
    chk("b16_st_addr", log_addr[0], 32'h41);
    chk("b16_st_data", log_data[0], 32'h0000_00A5);
    take_rsp();

    // reset during the second beat's WAIT
    sel = 1'b0; rdy_left = 1; nlog = 0; found = 1'b0;
    do_req(1'b1, 2'b10, 32'h300, 32'h1122_3344);
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_bus_clk && nlog == 1) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("mid_reached_wait2", 32'(found), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_req_ready", 32'(m_req_ready), 1);
    chk("mid_rsp_valid", 32'(m_rsp_valid), 0);
    chk("mid_rsp_err", 32'(m_rsp_err), 0);
    chk("mid_busy", 32'(m_busy), 0);
    chk("mid_bus_clk", 32'(m_bus_clk), 0);
    chk("mid_bus_we", 32'(m_bus_we), 0);
    chk("mid_bus_addr", m_bus_addr, 0);
    chk("mid_bus_data", m_bus_data, 0);
    chk("mid_rdata", m_rdata, 0);
    repeat (3) @(posedge clk);
    #1 chk("mid_no_rsp", 32'(m_rsp_valid), 0);
    rdy_left = 100; nlog = 0; rd_vals[0] = 32'h9A;
    do_req(1'b0, 2'b00, 32'h55, 32'h0);
    wait_rsp(k);
    chk("post_rst_rdata", m_rdata, 32'h9A);
    chk("post_rst_addr", log_addr[0], 32'h55);
    take_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpu_bus_seq.md
Name: cpu_bus_seq

Overview:
Parametrised bus-access sequencer between the CPU core and the external byte-wide bus (o_bus_clk / o_bus_we / o_bus_addr / o_bus_data / i_bus_data_ready). It accepts one load/store request of 1, 2 or 4 bytes and splits it into little-endian bus beats of BUS_W bits. Each beat is handshaked on i_bus_data_ready, with an optional timeout. It replaces the CPU's single-width bus handling with a width-generic engine that also reports errors, which the single-width handling lacks.

Parameters:
ADDR_W, 32, request and bus address width; addresses wrap modulo 2^ADDR_W.
DATA_W, 32, maximum request data width; must be 8, 16 or 32.
BUS_W, 8, external bus data width; must be 8, 16 or 32, and BUS_W <= DATA_W.
TIMEOUT_CYC, 255, wait-cycle limit per beat; 0 disables the timeout.

Ports:
i_cpu_clk  in  1  sole clock; all logic on rising edge.
i_rst_n  in  1  synchronous, active-low reset.
i_req_valid  in  1  request present.
o_req_ready  out  1  high only in IDLE.
i_req_we  in  1  1 = store, 0 = load.
i_req_size  in  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = reserved.
i_req_addr  in  ADDR_W  byte address of the least-significant byte.
i_req_wdata  in  DATA_W  store data; byte 0 in bits [7:0].
o_rsp_valid  out  1  response present; held until accepted.
i_rsp_ready  in  1  response accepted.
o_rsp_rdata  out  DATA_W  load data, zero-extended; 0 for stores.
o_rsp_err  out  1  error: timeout, reserved size, or size larger than DATA_W.
o_bus_clk  out  1  bus strobe.
o_bus_we  out  1  bus write enable.
o_bus_addr  out  ADDR_W  beat address.
o_bus_data  out  BUS_W  beat write data.
i_bus_data  in  BUS_W  beat read data.
i_bus_data_ready  in  1  beat complete.
o_busy  out  1  high when not in IDLE.

Behaviour:
- Reset (i_rst_n = 0 at a clock edge) puts the block in IDLE.
  - Reset values: o_req_ready = 1; o_rsp_valid, o_rsp_err, o_bus_clk, o_bus_we = 0; o_bus_addr, o_bus_data, o_rsp_rdata = 0; o_busy = 0.
  - Reset mid-transfer abandons the transfer immediately. No response is issued.
- Bytes per request: NB = 1 << i_req_size. Beats: NBEATS = max(1, NB*8/BUS_W). BPB = BUS_W/8 bytes per beat.
- A request is accepted on the edge where i_req_valid & o_req_ready. Address, size, we and wdata are captured; the beat index is cleared.
- Invalid request: reserved size, or NB*8 > DATA_W. Go straight to RESP with o_rsp_err = 1 and rdata = 0. No bus activity.
- Beat address: o_bus_addr = captured address + beat*BPB, truncated to ADDR_W (wraps). Misaligned addresses are allowed.
- Beat write data: o_bus_data = wdata[beat*BUS_W +: BUS_W]. When NB < BPB, unused upper lanes are driven 0.
- State machine:
  - IDLE: wait for accept. Go to SETUP on a valid request, or RESP on an invalid one.
  - SETUP (1 cycle): drive o_bus_addr, o_bus_we and o_bus_data; o_bus_clk = 0. Then go to WAIT.
  - WAIT: o_bus_clk = 1. Address, data and we are held stable.
    - On i_bus_data_ready = 1 for a load, capture i_bus_data into rdata lane[beat]. Upper lanes beyond NB bytes are masked to 0.
    - On ready, drop o_bus_clk. Go to SETUP for the next beat if beat < NBEATS-1, otherwise go to RESP.
    - Timeout (TIMEOUT_CYC != 0): the wait counter counts WAIT cycles without ready. When it reaches TIMEOUT_CYC, go to RESP with o_rsp_err = 1. Lanes not yet received stay 0, and remaining beats are skipped.
    - The counter clears at every SETUP.
  - RESP: o_rsp_valid = 1; rdata and err are held stable. o_bus_clk and o_bus_we = 0. On i_rsp_ready, go to IDLE.
- Latency: each beat takes a minimum of 2 cycles. A 1-byte load with ready on the first WAIT cycle gives o_rsp_valid 3 cycles after the accept edge.
- o_req_ready is 0 in RESP, so a new request is never accepted in the same cycle a response is accepted.
- i_bus_data_ready is ignored outside WAIT.

Decomposition:
- Package cpu_bus_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - state enum (ST_IDLE, ST_SETUP, ST_WAIT, ST_RESP);
  - helper function for beat count.
- One sub-module, cpu_bus_timer: wait counter with clear, enable and limit, and an expired output; width $clog2(TIMEOUT_CYC+1).

Test Plan:
1. BUS_W=8; store size=10, addr=0x0000_01FE, wdata=0xAABBCCDD, ready on first WAIT cycle -> 4 beats at 0x1FE/0x1FF/0x200/0x201 carrying DD/CC/BB/AA, o_bus_we=1; rsp_valid at cycle 9 after accept, err=0.
2. BUS_W=8; load size=01, addr=0xFFFF_FFFF, bus returns 0x34 then 0x12 -> beat addrs 0xFFFF_FFFF then 0x0000_0000 (wrap); rdata=0x0000_1234.
3. TIMEOUT_CYC=4; load size=00, ready never asserted -> o_bus_clk high for exactly 4 WAIT cycles; rsp_err=1, rdata=0; back to IDLE after i_rsp_ready.
4. Request size=11 -> no o_bus_clk pulse; rsp_valid next cycle with err=1. Hold i_rsp_ready=0 for 5 cycles -> response stays stable and o_req_ready stays 0.
5. BUS_W=16; load size=10, addr=0x100, bus returns 0x5678 then 0x1234 -> addrs 0x100, 0x102; rdata=0x12345678. Then size=00 load returning 0xBEEF -> rdata=0x000000EF.
6. Assert i_rst_n=0 during WAIT of beat 2 -> next cycle all outputs at reset values, no rsp_valid; a following request completes normally.
